// File: rtl/pkt_buf_rd_if.sv
// Command, RAM read-port and output-stream signals of the packet buffer reader.
// The reader itself connects through the master modport.
interface pkt_buf_rd_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [ADDR_WIDTH:0]   cmd_len;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_dout;
   logic                  m_tvalid;
   logic                  m_tready;
   logic [DATA_WIDTH-1:0] m_tdata;
   logic                  m_tlast;
   logic                  busy;

   modport master (
      input  cmd_valid, cmd_addr, cmd_len, ram_dout, m_tready,
      output cmd_ready, ram_addr, m_tvalid, m_tdata, m_tlast, busy
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_len, ram_dout, m_tready,
      input  cmd_ready, ram_addr, m_tvalid, m_tdata, m_tlast, busy
   );
endinterface

// File: rtl/pkt_buf_rd.sv
// Streams a frame of words out of a synchronous-read RAM, wrapping at the buffer end,
// through a 2-entry skid FIFO so reads issued ahead of a stalled sink are never lost.
module pkt_buf_rd #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   pkt_buf_rd_if.master     bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           ram_addr_q, ram_addr_d;
   logic [ADDR_WIDTH:0]             left_q, left_d;
   logic                            inflight_q, inflight_d;
   logic                            inflight_last_q, inflight_last_d;
   logic [1:0][DATA_WIDTH-1:0]      mem_q, mem_d;
   logic [1:0]                      last_q, last_d;
   logic                            wr_ptr_q, wr_ptr_d;
   logic                            rd_ptr_q, rd_ptr_d;
   logic [1:0]                      count_q, count_d;
   logic                            pop_s;
   logic                            issue_s;

   always_comb begin
      state_d         = state_q;
      ram_addr_d      = ram_addr_q;
      left_d          = left_q;
      mem_d           = mem_q;
      last_d          = last_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      pop_s           = (count_q != 2'd0) && bus.m_tready;
      // Occupancy counts stored beats plus the read whose data lands next edge.
      issue_s         = (state_q == RUN) &&
                        (({1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s}) < 3'd2);
      inflight_d      = issue_s;
      inflight_last_d = issue_s && (left_q == (ADDR_WIDTH+1)'(1));

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && (bus.cmd_len != '0)) begin
               ram_addr_d = bus.cmd_addr;
               left_d     = bus.cmd_len;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (issue_s) begin
               ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
               left_d     = left_q - (ADDR_WIDTH+1)'(1);
               if (left_q == (ADDR_WIDTH+1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop_s && last_q[rd_ptr_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (inflight_q) begin
         mem_d[wr_ptr_q]  = bus.ram_dout;
         last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({inflight_q, pop_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         ram_addr_q      <= '0;
         left_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         mem_q           <= '0;
         last_q          <= 2'b00;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
      end else begin
         state_q         <= state_d;
         ram_addr_q      <= ram_addr_d;
         left_q          <= left_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         mem_q           <= mem_d;
         last_q          <= last_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE) && !rst;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.m_tvalid  = (count_q != 2'd0);
   assign bus.m_tdata   = mem_q[rd_ptr_q];
   assign bus.m_tlast   = (count_q != 2'd0) && last_q[rd_ptr_q];
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_pkt_buf_rd.sv
// Drives read commands against a behavioural RAM and checks the stream against
// an expected-beat queue built from the frame address/length rules.
module tb_pkt_buf_rd;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [DW-1:0] mem [DEPTH];

   pkt_buf_rd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   pkt_buf_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data for the sampled address appears after the edge.
   always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
      chk({tag, "_ram_addr"},  64'(bus.ram_addr),  64'd0);
      chk({tag, "_tvalid"},    64'(bus.m_tvalid),  64'd0);
      chk({tag, "_tlast"},     64'(bus.m_tlast),   64'd0);
      chk({tag, "_tdata"},     64'(bus.m_tdata),   64'd0);
      chk({tag, "_busy"},      64'(bus.busy),      64'd0);
   endtask

   // One frame: issue command, then per cycle set m_tready and compare against the queue.
   task automatic frame(input int addr, input int len, input int pct, input int abort_after);
      logic [DW:0] exp_q[$];
      logic [DW:0] head;
      int c = 0;
      int pops = 0;
      int busy_cnt = 0;
      bit idle_seen = 1'b0;
      bit rdy;
      for (int k = 0; k < len; k++)
         exp_q.push_back({(k == len - 1), mem[(addr + k) % DEPTH]});
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = AW'(addr);
      bus.cmd_len   = (AW+1)'(len);
      chk("cmd_ready_pre", 64'(bus.cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_len   = (AW+1)'($urandom);
      while (!(idle_seen && c >= 4)) begin
         @(negedge clk);
         rdy = ($urandom_range(99) < pct);
         bus.m_tready = rdy;
         chk("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
         chk("cmd_ready", 64'(bus.cmd_ready), 64'(exp_q.size() == 0));
         if (bus.busy) busy_cnt++;
         if (c < 2)
            chk("first_latency", 64'(bus.m_tvalid), 64'd0);
         else if (pct >= 100)
            chk("no_bubble", 64'(bus.m_tvalid), 64'(exp_q.size() != 0));
         if (exp_q.size() == 0) begin
            chk("no_extra_beat", 64'(bus.m_tvalid), 64'd0);
            idle_seen = 1'b1;
         end else if (bus.m_tvalid) begin
            head = exp_q[0];
            chk("tdata", 64'(bus.m_tdata), 64'(head[DW-1:0]));
            chk("tlast", 64'(bus.m_tlast), 64'(head[DW]));
            if (rdy) begin
               void'(exp_q.pop_front());
               pops++;
               if (abort_after != 0 && pops == abort_after) begin
                  @(posedge clk);
                  return;
               end
            end
         end
         c++;
         if (c > 40 * len + 40) begin
            chk("timeout_beats_left", 64'(exp_q.size()), 64'd0);
            break;
         end
      end
      bus.m_tready = 1'b0;
      if (pct >= 100 && len > 0)
         chk("busy_cycles", 64'(busy_cnt), 64'(len + 2));
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.m_tready  = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

      frame(32'h10, 4, 100, 0);
      frame(32'hFE, 4, 100, 0);
      frame(32'h20, 6, 50, 0);
      frame(32'h30, 0, 100, 0);
      frame(32'h80, 256, 100, 0);
      frame(32'hFF, 1, 100, 0);

      // Reset mid-frame, then a fresh short frame must deliver only its own beats.
      frame(32'h40, 8, 100, 2);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midframe_reset");
      @(negedge clk);
      chk_reset_outputs("midframe_reset_hold");
      rst = 1'b0;
      #1;
      chk("ready_after_midreset", 64'(bus.cmd_ready), 64'd1);
      frame(32'h60, 2, 100, 0);

      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int f = 0; f < 8; f++)
         frame(int'($urandom_range(DEPTH - 1)), int'($urandom_range(12, 1)),
               int'($urandom_range(100, 30)), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
